// File: rtl/rnm_sar_adc_if.sv
// Analog-in / code-out bundle for the RNM SAR ADC: controls and real-valued
// nodes driven toward the converter, conversion results returned.
interface rnm_sar_adc_if #(
  parameter int N = 8
);
  logic         en;
  logic         start;
  real          vin;
  real          vdd;
  logic [N-1:0] code;
  logic         valid;
  logic         busy;

  modport master (
    output en, start, vin, vdd,
    input  code, valid, busy
  );

  modport slave (
    input  en, start, vin, vdd,
    output code, valid, busy
  );
endinterface

// File: rtl/rnm_sar_adc.sv
// Real-number-modelled SAR ADC: samples vin, resolves one bit per clock MSB first.
// Optional macro RNM_SAR_ADC_CONT_EN: back-to-back conversions while en stays high.
module rnm_sar_adc #(
  parameter int N = 8
) (
  input  logic         sampling_Clk,
  input  logic         rst,
  rnm_sar_adc_if.slave adc
);
  localparam int BW = $clog2(N);

  typedef enum logic {IDLE, CONV} state_t;

  state_t         state, state_nxt;
  real            held, held_nxt;
  logic           vdd_ok, vdd_ok_nxt;
  logic [N-1:0]   acc, acc_nxt;
  logic [N-1:0]   code_r, code_nxt;
  logic [BW-1:0]  bit_idx, bit_nxt;
  logic           valid_r, valid_nxt;
  logic           busy_r, busy_nxt;
  logic [N-1:0]   trial;
  logic [N-1:0]   acc_kept;
  real            threshold;

  always_ff @(posedge sampling_Clk) begin
    if (rst) begin
      state   <= IDLE;
      held    <= 0.0;
      vdd_ok  <= 1'b0;
      acc     <= '0;
      code_r  <= '0;
      bit_idx <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      held    <= held_nxt;
      vdd_ok  <= vdd_ok_nxt;
      acc     <= acc_nxt;
      code_r  <= code_nxt;
      bit_idx <= bit_nxt;
      valid_r <= valid_nxt;
      busy_r  <= busy_nxt;
    end
  end

  // A dead supply at the sample edge forces every trial bit to be rejected,
  // otherwise a zero reference would make every comparison pass.
  always_comb begin
    trial     = acc | (N'(1) << bit_idx);
    threshold = real'(trial) * adc.vdd / real'(2 ** N);
    acc_kept  = (vdd_ok && (held >= threshold)) ? trial : acc;
  end

  always_comb begin
    state_nxt  = state;
    held_nxt   = held;
    vdd_ok_nxt = vdd_ok;
    acc_nxt    = acc;
    code_nxt   = code_r;
    bit_nxt    = bit_idx;
    valid_nxt  = 1'b0;
    busy_nxt   = busy_r;

    case (state)
      IDLE: begin
        if (adc.en && adc.start) begin
          held_nxt   = adc.vin;
          vdd_ok_nxt = (adc.vdd > 0.0);
          acc_nxt    = '0;
          bit_nxt    = BW'(N - 1);
          busy_nxt   = 1'b1;
          state_nxt  = CONV;
        end
      end
      CONV: begin
        if (!adc.en) begin
          // Abort wins over a completion on the same edge.
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (bit_idx == '0) begin
          code_nxt  = acc_kept;
          valid_nxt = 1'b1;
`ifdef RNM_SAR_ADC_CONT_EN
          held_nxt   = adc.vin;
          vdd_ok_nxt = (adc.vdd > 0.0);
          acc_nxt    = '0;
          bit_nxt    = BW'(N - 1);
`else
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
`endif
        end else begin
          acc_nxt = acc_kept;
          bit_nxt = bit_idx - 1'b1;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign adc.code  = code_r;
  assign adc.valid = valid_r;
  assign adc.busy  = busy_r;
endmodule

// File: tb/tb_rnm_sar_adc.sv
// Scoreboard bench for rnm_sar_adc: stimulus pushes expected code and completion cycle, a monitor pops on valid.
module tb_rnm_sar_adc;
  localparam int N = 8;
`ifdef RNM_SAR_ADC_CONT_EN
  localparam logic BUSY_AT_VALID = 1'b1;
`else
  localparam logic BUSY_AT_VALID = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] code;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t e_mon;

  rnm_sar_adc_if #(.N(N)) adc_bus ();

  rnm_sar_adc #(.N(N)) dut (
    .sampling_Clk (clk),
    .rst          (rst),
    .adc          (adc_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && adc_bus.valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(adc_bus.valid), 0);
      end else begin
        e_mon = sb.pop_front();
        chk("code", 32'(adc_bus.code), 32'(e_mon.code));
        chk("valid_cycle", cyc, e_mon.cyc);
        chk("busy_at_valid", 32'(adc_bus.busy), 32'(BUSY_AT_VALID));
      end
    end
  end

  // Caller is at a negedge; returns at the negedge where valid is visible.
  task automatic convert(input real v, input real d, input real v_after, input int exp);
    int e0;
    adc_bus.vin   = v;
    adc_bus.vdd   = d;
    adc_bus.start = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{code: N'(exp), cyc: e0 + N});
    @(negedge clk);
    adc_bus.start = 1'b0;
    adc_bus.vin   = v_after;
    chk("busy_after_accept", 32'(adc_bus.busy), 1);
    repeat (N) @(negedge clk);
  endtask

  task automatic abort_at(input int d);
    int e0;
    logic [N-1:0] prev;
    prev = adc_bus.code;
    adc_bus.vin   = 0.75;
    adc_bus.vdd   = 1.0;
    adc_bus.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    adc_bus.start = 1'b0;
    while (cyc < e0 + d) @(negedge clk);
    chk("busy_before_abort", 32'(adc_bus.busy), 1);
    adc_bus.en = 1'b0;
    @(negedge clk);
    chk("busy_after_abort", 32'(adc_bus.busy), 0);
    chk("code_kept_after_abort", 32'(adc_bus.code), 32'(prev));
    adc_bus.en = 1'b1;
    repeat (N + 2) @(negedge clk);
  endtask

  function automatic int model(input real v, input real d);
    real x;
    if (d <= 0.0) return 0;
    x = v * real'(2 ** N) / d;
    if (x < 0.0) return 0;
    if (x >= real'(2 ** N - 1)) return 2 ** N - 1;
    return int'($floor(x));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int e0;
    real v, va;
    adc_bus.en    = 1'b1;
    adc_bus.start = 1'b0;
    adc_bus.vin   = 0.0;
    adc_bus.vdd   = 1.0;
    repeat (2) @(negedge clk);
    chk("reset_code", 32'(adc_bus.code), 0);
    chk("reset_valid", 32'(adc_bus.valid), 0);
    chk("reset_busy", 32'(adc_bus.busy), 0);
    rst = 1'b0;

`ifdef RNM_SAR_ADC_CONT_EN
    adc_bus.vin   = 0.25;
    adc_bus.start = 1'b1;
    e0 = cyc + 1;
    for (int k = 1; k <= 3; k++) sb.push_back('{code: N'(64), cyc: e0 + k * N});
    @(negedge clk);
    adc_bus.start = 1'b0;
    while (cyc < e0 + 3 * N) @(negedge clk);
    adc_bus.en = 1'b0;
    @(negedge clk);
    chk("cont_busy_after_en_low", 32'(adc_bus.busy), 0);
    adc_bus.en = 1'b1;
    repeat (N + 2) @(negedge clk);
`else
    // Reset mid-conversion, then a start on the first edge after release.
    adc_bus.vin   = 0.9;
    adc_bus.start = 1'b1;
    @(negedge clk);
    adc_bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midconv_reset_code", 32'(adc_bus.code), 0);
    chk("midconv_reset_valid", 32'(adc_bus.valid), 0);
    chk("midconv_reset_busy", 32'(adc_bus.busy), 0);
    rst = 1'b0;
    convert(0.5, 1.0, 0.5, 8'h80);

    convert(0.25, 1.0, 0.25, 8'h40);
    convert(0.3, 1.0, 0.3, 76);
    convert(-0.1, 1.0, -0.1, 0);
    convert(1.2, 1.0, 1.2, 255);
    convert(0.999, 1.0, 0.999, 255);
    convert(0.5, 0.0, 0.5, 0);
    convert(0.5, 1.0, 0.0, 8'h80);
    convert(0.3, 1.0, 0.3, 76);

    abort_at(4);
    abort_at(N - 1);

    // start held through CONV: only a second conversion at E0+N+1.
    @(negedge clk);
    adc_bus.vin   = 0.25;
    adc_bus.vdd   = 1.0;
    adc_bus.start = 1'b1;
    e0 = cyc + 1;
    sb.push_back('{code: N'(64), cyc: e0 + N});
    sb.push_back('{code: N'(64), cyc: e0 + 2 * N + 1});
    while (cyc < e0 + N + 1) @(negedge clk);
    adc_bus.start = 1'b0;
    while (cyc < e0 + 2 * N + 1) @(negedge clk);
    @(negedge clk);

    // Sine-driven node with the value moving after each sample edge.
    for (int k = 0; k < 6; k++) begin
      v  = 0.5 + 0.6 * $sin(real'(k) * 1.3);
      va = 0.5 + 0.6 * $sin(real'(k) * 1.3 + 0.5);
      convert(v, 1.0, va, model(v, 1.0));
    end
    repeat (3) @(negedge clk);
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
